pe_array: RTL and testbench

PE_ARRAY -- requirements
Module: pe_array

---
 rtl/pe_pkg.sv | 67 ++++++
 rtl/pe_unit.sv | 147 ++++++++++++++
 rtl/pe_array.sv | 45 ++++
 tb/tb_pe_array.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types, moduli and modular helpers for the PE array datapath.
// Butterfly opcodes are built only when PE_ARRAY_BFO_EN is defined.
package pe_pkg;

  typedef enum logic [4:0] {
    MADD   = 5'd0,
    MSUB   = 5'd1,
    MMUL   = 5'd2,
    MMAC   = 5'd3,
    RSV_4  = 5'd4,
    RSV_5  = 5'd5,
    CT_BFO = 5'd6,
    GS_BFO = 5'd7,
    P2R    = 5'd8,
    RSV_9  = 5'd9,
    RSV_10 = 5'd10,
    RSV_11 = 5'd11,
    RSV_12 = 5'd12,
    RSV_13 = 5'd13,
    RSV_14 = 5'd14,
    CMP_0  = 5'd15,
    CMP_1  = 5'd16,
    CMP_2  = 5'd17,
    CMP_3  = 5'd18,
    CMP_4  = 5'd19,
    CMP_5  = 5'd20,
    CMP_6  = 5'd21,
    CMP_7  = 5'd22,
    CMP_8  = 5'd23,
    CMP_9  = 5'd24,
    CMP_10 = 5'd25,
    CMP_11 = 5'd26
  } pe_instr_t;

  typedef enum logic [4:0] {
    KEM_512  = 5'd0,
    KEM_768  = 5'd1,
    KEM_1024 = 5'd2,
    DSA_44   = 5'd3,
    DSA_65   = 5'd4,
    DSA_87   = 5'd5
  } pe_alg_t;

  localparam int QW = 23;
  localparam logic [QW-1:0] Q_KEM = 23'd3329;
  localparam logic [QW-1:0] Q_DSA = 23'd8380417;

  // Every code above KEM_1024, including undefined ones, selects the DSA modulus.
  function automatic logic [QW-1:0] q_of(input logic [4:0] alg_code);
    return (alg_code <= 5'd2) ? Q_KEM : Q_DSA;
  endfunction

  function automatic logic [QW-1:0] add_mod(input logic [QW-1:0] x, input logic [QW-1:0] y,
                                            input logic [QW-1:0] q);
    logic [QW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[QW-1:0];
  endfunction

  // x + q - y may wrap intermediately, but the true result is below q < 2^QW.
  function automatic logic [QW-1:0] sub_mod(input logic [QW-1:0] x, input logic [QW-1:0] y,
                                            input logic [QW-1:0] q);
    return (x >= y) ? (x - y) : (x + q - y);
  endfunction

endpackage

// File: rtl/pe_unit.sv
// One processing element: reduce operands, multiply/reduce, then combine; 3 register stages.
// CT_BFO/GS_BFO are implemented only when PE_ARRAY_BFO_EN is defined.
module pe_unit
  import pe_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  pe_alg_t          i_alg,
  input  pe_instr_t        i_instr,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_out0,
  output logic [WIDTH-1:0] o_out1
);

  localparam int XW = (WIDTH > 2 * QW) ? WIDTH : 2 * QW;

  function automatic logic [QW-1:0] mod_reduce(input logic [XW-1:0] x, input logic [QW-1:0] q);
    return (q == Q_KEM) ? QW'(x % XW'(Q_KEM)) : QW'(x % XW'(Q_DSA));
  endfunction

  // Stage 1: operands reduced into [0,q)
  logic [QW-1:0] w_q0;
  logic [QW-1:0] r_a1, r_b1, r_c1;
  pe_instr_t     r_op1;
  pe_alg_t       r_alg1;

  assign w_q0 = q_of(i_alg);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a1   <= '0;
      r_b1   <= '0;
      r_c1   <= '0;
      r_op1  <= MADD;
      r_alg1 <= KEM_512;
    end else begin
      r_a1   <= mod_reduce(XW'(i_a), w_q0);
      r_b1   <= mod_reduce(XW'(i_b), w_q0);
      r_c1   <= mod_reduce(XW'(i_c), w_q0);
      r_op1  <= i_instr;
      r_alg1 <= i_alg;
    end
  end

  // Stage 2: the single modular product plus the sum/difference terms
  logic [QW-1:0]   w_q1, w_diff1, w_mx, w_my, w_prod;
  logic [2*QW-1:0] w_full;
  logic [QW-1:0]   r_p2, r_s2, r_d2, r_c2;
  pe_instr_t       r_op2;
  pe_alg_t         r_alg2;
`ifdef PE_ARRAY_BFO_EN
  logic [QW-1:0]   r_a2;
`endif

  assign w_q1    = q_of(r_alg1);
  assign w_diff1 = sub_mod(r_a1, r_b1, w_q1);

  always_comb begin
    w_mx = r_a1;
    w_my = r_b1;
`ifdef PE_ARRAY_BFO_EN
    if (r_op1 == CT_BFO) begin
      w_mx = r_b1;
      w_my = r_c1;
    end else if (r_op1 == GS_BFO) begin
      w_mx = w_diff1;
      w_my = r_c1;
    end
`endif
  end

  assign w_full = {{QW{1'b0}}, w_mx} * {{QW{1'b0}}, w_my};
  assign w_prod = mod_reduce(XW'(w_full), w_q1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p2   <= '0;
      r_s2   <= '0;
      r_d2   <= '0;
      r_c2   <= '0;
      r_op2  <= MADD;
      r_alg2 <= KEM_512;
`ifdef PE_ARRAY_BFO_EN
      r_a2   <= '0;
`endif
    end else begin
      r_p2   <= w_prod;
      r_s2   <= add_mod(r_a1, r_b1, w_q1);
      r_d2   <= w_diff1;
      r_c2   <= r_c1;
      r_op2  <= r_op1;
      r_alg2 <= r_alg1;
`ifdef PE_ARRAY_BFO_EN
      r_a2   <= r_a1;
`endif
    end
  end

  // Stage 3: select/combine per opcode; unknown opcodes yield zeros
  logic [QW-1:0]    w_q2, w_o0, w_o1;
  logic [WIDTH-1:0] r_out0, r_out1;

  assign w_q2 = q_of(r_alg2);

  always_comb begin
    w_o0 = '0;
    w_o1 = '0;
    case (r_op2)
      MADD: w_o0 = r_s2;
      MSUB: w_o0 = r_d2;
      MMUL: w_o0 = r_p2;
      MMAC: w_o0 = add_mod(r_p2, r_c2, w_q2);
`ifdef PE_ARRAY_BFO_EN
      CT_BFO: begin
        w_o0 = add_mod(r_a2, r_p2, w_q2);
        w_o1 = sub_mod(r_a2, r_p2, w_q2);
      end
      GS_BFO: begin
        w_o0 = r_s2;
        w_o1 = r_p2;
      end
`endif
      default: begin
        w_o0 = '0;
        w_o1 = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out0 <= '0;
      r_out1 <= '0;
    end else begin
      r_out0 <= WIDTH'(w_o0);
      r_out1 <= WIDTH'(w_o1);
    end
  end

  assign o_out0 = r_out0;
  assign o_out1 = r_out1;

endmodule

// File: rtl/pe_array.sv
// NUM independent modular-arithmetic PEs sharing broadcast alg/instr, latency 3.
// Define PE_ARRAY_BFO_EN to build the CT_BFO/GS_BFO butterfly opcodes.
module pe_array
  import pe_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int NUM     = 4,
  parameter int IN_NUM  = 3,
  parameter int OUT_NUM = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  pe_alg_t          alg,
  input  pe_instr_t        instr,
  input  logic [WIDTH-1:0] data_in  [0:NUM-1][0:IN_NUM-1],
  output logic [WIDTH-1:0] data_out [0:NUM-1][0:OUT_NUM-1]
);

  logic [WIDTH-1:0] w_res [0:NUM-1][0:1];

  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_pe
      pe_unit #(.WIDTH(WIDTH)) u_pe (
        .clk     (clk),
        .rst     (rst),
        .i_alg   (alg),
        .i_instr (instr),
        .i_a     (data_in[gi][0]),
        .i_b     (data_in[gi][1]),
        .i_c     (data_in[gi][2]),
        .o_out0  (w_res[gi][0]),
        .o_out1  (w_res[gi][1])
      );
      // Result slots beyond the two a PE produces are tied off.
      for (genvar go = 0; go < OUT_NUM; go++) begin : g_out
        if (go < 2) begin : g_live
          assign data_out[gi][go] = w_res[gi][go];
        end else begin : g_zero
          assign data_out[gi][go] = '0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pe_array.sv
// Scoreboard bench for pe_array: driver queues expectations, monitor checks each output cycle.
// Honours PE_ARRAY_BFO_EN when deciding whether butterflies produce results.
module tb_pe_array;
  import pe_pkg::*;

  localparam int W  = 24;
  localparam int N  = 4;
  localparam int NI = 3;
  localparam int NO = 2;
`ifdef PE_ARRAY_BFO_EN
  localparam bit BFO = 1'b1;
`else
  localparam bit BFO = 1'b0;
`endif

  typedef logic [N-1:0][NO-1:0][W-1:0] exp_t;
  typedef struct packed {
    logic       rst;
    logic [4:0] op;
    exp_t       exp;
  } item_t;

  logic      clk = 1'b0;
  logic      rst;
  pe_alg_t   alg;
  pe_instr_t instr;
  logic [W-1:0] data_in  [0:N-1][0:NI-1];
  logic [W-1:0] data_out [0:N-1][0:NO-1];

  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    edge_no = 0;

  pe_array #(.WIDTH(W), .NUM(N), .IN_NUM(NI), .OUT_NUM(NO)) dut (
    .clk      (clk),
    .rst      (rst),
    .alg      (alg),
    .instr    (instr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic longint modp(input longint x, input longint q);
    return ((x % q) + q) % q;
  endfunction

  // Reference: straight integer arithmetic on the raw operands.
  function automatic logic [W-1:0] ref_out(input int op, input int al, input longint a,
                                           input longint b, input longint c, input int k);
    longint q;
    longint r;
    q = (al <= 2) ? 64'd3329 : 64'd8380417;
    r = 0;
    case (op)
      0: r = (k == 0) ? modp(a + b, q) : 0;
      1: r = (k == 0) ? modp(a - b, q) : 0;
      2: r = (k == 0) ? modp(a * b, q) : 0;
      3: r = (k == 0) ? modp(a * b + c, q) : 0;
      6: if (BFO) r = (k == 0) ? modp(a + b * c, q) : modp(a - b * c, q);
      7: if (BFO) r = (k == 0) ? modp(a + b, q) : modp((a - b) * c, q);
      default: r = 0;
    endcase
    return W'(r);
  endfunction

  function automatic exp_t all_exp(input logic [W-1:0] o0, input logic [W-1:0] o1);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e[i][0] = o0;
      e[i][1] = o1;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 9))
      0: return 24'd0;
      1: return 24'd3328;
      2: return 24'd3329;
      3: return 24'd8380416;
      4: return 24'd8380417;
      5: return 24'hFFFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic set_all(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    for (int i = 0; i < N; i++) begin
      data_in[i][0] = a;
      data_in[i][1] = b;
      data_in[i][2] = c;
    end
  endtask

  // Drive one cycle of inputs and queue what they should produce three edges later.
  task automatic issue(input bit r, input int op, input int al, input bit use_model, input exp_t given);
    item_t it;
    rst   = r;
    instr = pe_instr_t'(5'(op));
    alg   = pe_alg_t'(5'(al));
    it.rst = r;
    it.op  = 5'(op);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < NO; k++)
        it.exp[i][k] = use_model ? ref_out(op, al, longint'(data_in[i][0]), longint'(data_in[i][1]),
                                           longint'(data_in[i][2]), k) : given[i][k];
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Monitor: an output is valid only if no reset hit any of the three edges it travelled.
  initial begin
    item_t h0, h1, h2, cur;
    logic [W-1:0] want;
    h0 = '0; h0.rst = 1'b1;
    h1 = h0;
    h2 = h0;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        edge_no++;
        h2 = h1;
        h1 = h0;
        h0 = cur;
        for (int i = 0; i < N; i++) begin
          for (int k = 0; k < NO; k++) begin
            want = (h0.rst || h1.rst || h2.rst) ? '0 : h2.exp[i][k];
            checks++;
            if (data_out[i][k] !== want) begin
              errors++;
              $display("FAIL out[%0d][%0d] edge=%0d got=%0d want=%0d", i, k, edge_no, data_out[i][k], want);
            end
          end
        end
        $display("txn edge=%0d op=%0d rst=%0b out00=%0d out01=%0d", edge_no, h2.op,
                 (h0.rst || h1.rst || h2.rst), data_out[0][0], data_out[0][1]);
      end
    end
  end

  initial begin
    exp_t e;
    int op, al;
    bit r;
    set_all(0, 0, 0);
    repeat (3) issue(1'b1, 0, 0, 1'b1, '0);
    issue(1'b0, 0, 0, 1'b1, '0);

    // Mixed operands per PE under DSA_44 multiply
    data_in[0][0] = 24'd100000; data_in[0][1] = 24'd8191000; data_in[0][2] = 24'd767;
    data_in[1][0] = 24'd8191;   data_in[1][1] = 24'd767;     data_in[1][2] = 24'd32;
    for (int i = 2; i < N; i++) begin
      data_in[i][0] = 24'd32; data_in[i][1] = 24'd32; data_in[i][2] = 24'd32;
    end
    e = all_exp(24'd1024, 24'd0);
    e[0][0] = 24'd6422837;
    e[1][0] = 24'd6282497;
    issue(1'b0, 2, 3, 1'b0, e);

    set_all(3000, 3000, 2000);
    issue(1'b0, 2, 1, 1'b0, all_exp(24'd1713, 24'd0));
    issue(1'b0, 3, 1, 1'b0, all_exp(24'd384, 24'd0));
    set_all(5, 10, 0);
    issue(1'b0, 1, 4, 1'b0, all_exp(24'd8380412, 24'd0));
    set_all(3000, 1000, 0);
    issue(1'b0, 0, 0, 1'b0, all_exp(24'd671, 24'd0));
    set_all(10, 3, 4);
    issue(1'b0, 6, 5, 1'b0, BFO ? all_exp(24'd22, 24'd8380415) : all_exp(24'd0, 24'd0));
    issue(1'b0, 7, 5, 1'b0, BFO ? all_exp(24'd13, 24'd28) : all_exp(24'd0, 24'd0));
    // Back-to-back opcode change, then reserved P2R with live data
    set_all(3000, 1000, 0);
    issue(1'b0, 0, 0, 1'b0, all_exp(24'd671, 24'd0));
    set_all(3000, 3000, 0);
    issue(1'b0, 2, 1, 1'b0, all_exp(24'd1713, 24'd0));
    set_all(123, 456, 789);
    issue(1'b0, 8, 3, 1'b0, all_exp(24'd0, 24'd0));

    // Reset one cycle after a multiply must swallow it
    set_all(3000, 3000, 0);
    issue(1'b0, 2, 1, 1'b1, '0);
    issue(1'b1, 2, 1, 1'b1, '0);
    set_all(0, 0, 0);
    repeat (4) issue(1'b0, 0, 0, 1'b1, '0);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < NI; j++)
          data_in[i][j] = pick_operand();
      case ($urandom_range(0, 7))
        0: op = 0;
        1: op = 1;
        2: op = 2;
        3: op = 3;
        4: op = 6;
        5: op = 7;
        default: op = int'($urandom_range(0, 31));
      endcase
      al = int'($urandom_range(0, 31));
      r  = ($urandom_range(0, 24) == 0);
      issue(r, op, al, 1'b1, '0);
    end

    set_all(0, 0, 0);
    repeat (4) issue(1'b0, 0, 0, 1'b1, '0);

    for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(negedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
